editor_hora_bcd: RTL and testbench

//   Downstream consumer of the one-cycle button pulses produced by the debounce/edge stage.

---
 rtl/editor_hora_bcd.sv | 157 +++++++++++++++
 tb/tb_editor_hora_bcd.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/editor_hora_bcd.sv
// editor_hora_bcd: BCD time editor (HH:MM:SS) driven by one-cycle button pulses.
// While idle the displayed time follows the RTC read path. In edit mode the
// selected field is stepped up or down in BCD with per-field wrap and no carry
// into neighbouring fields. A commit hands the time to the RTC writer through a
// level request that is held until it is acknowledged.
module editor_hora_bcd #(
  parameter bit          FORMATO_24  = 1'b1,
  parameter logic [31:0] TIMEOUT_CIC = 32'd500_000_000
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic        pb_prog,
  input  logic        pb_izq,
  input  logic        pb_der,
  input  logic        pb_arriba,
  input  logic        pb_abajo,
  input  logic        carga,
  input  logic [23:0] hora_in,
  input  logic        wr_ack,
  output logic [23:0] hora_out,
  output logic [1:0]  campo_sel,
  output logic        editando,
  output logic        wr_req
);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    EDITAR   = 2'd1,
    ESCRIBIR = 2'd2
  } estado_t;

  localparam logic [23:0] HORA_RST = FORMATO_24 ? 24'h000000 : 24'h120000;
  localparam logic [7:0]  HH_MIN   = FORMATO_24 ? 8'h00 : 8'h01;
  localparam logic [7:0]  HH_MAX   = FORMATO_24 ? 8'h23 : 8'h12;
  localparam logic [7:0]  MS_MIN   = 8'h00;
  localparam logic [7:0]  MS_MAX   = 8'h59;

  estado_t     estado_q, estado_d;
  logic [23:0] hora_q, hora_d;
  logic [1:0]  campo_q, campo_d;
  logic [31:0] cnt_q, cnt_d;

  logic hay_pulso;
  logic tmo_fin;

  // True when both digits are decimal and the value lies inside [vmin, vmax].
  // For valid BCD the binary order equals the decimal order.
  function automatic logic bcd_valido(input logic [7:0] v,
                                      input logic [7:0] vmin,
                                      input logic [7:0] vmax);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= vmin) && (v <= vmax);
  endfunction

  // One BCD step with wrap between vmin and vmax. A value outside the range
  // (possible after a raw load from the RTC) is forced to vmin.
  function automatic logic [7:0] bcd_paso(input logic [7:0] v,
                                          input logic       subir,
                                          input logic [7:0] vmin,
                                          input logic [7:0] vmax);
    logic [7:0] r;
    if (!bcd_valido(v, vmin, vmax)) begin
      r = vmin;
    end else if (subir) begin
      if (v == vmax)             r = vmin;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == vmin)             r = vmax;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  assign hay_pulso = pb_prog | pb_izq | pb_der | pb_arriba | pb_abajo;
  assign tmo_fin   = (TIMEOUT_CIC != 32'd0) && !hay_pulso &&
                     (cnt_q == TIMEOUT_CIC - 32'd1);

  // State register; async reset returns to idle so wr_req drops at once.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) estado_q <= REPOSO;
    else         estado_q <= estado_d;
  end

  // Data registers: displayed time, selected field, idle counter.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      hora_q  <= HORA_RST;
      campo_q <= 2'd0;
      cnt_q   <= 32'd0;
    end else begin
      hora_q  <= hora_d;
      campo_q <= campo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: commit has priority over the idle timeout.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO:   if (pb_prog) estado_d = EDITAR;
      EDITAR: begin
        if (pb_prog)      estado_d = ESCRIBIR;
        else if (tmo_fin) estado_d = REPOSO;
      end
      ESCRIBIR: if (wr_ack) estado_d = REPOSO;
      default:  estado_d = REPOSO;
    endcase
  end

  // Datapath: load from RTC when idle, field navigation and BCD stepping when editing.
  always_comb begin
    hora_d  = hora_q;
    campo_d = campo_q;
    cnt_d   = cnt_q;
    case (estado_q)
      REPOSO: begin
        if (carga) hora_d = hora_in;
        if (pb_prog) begin
          campo_d = 2'd0;
          cnt_d   = 32'd0;
        end
      end
      EDITAR: begin
        if (hay_pulso)                 cnt_d = 32'd0;
        else if (TIMEOUT_CIC != 32'd0) cnt_d = cnt_q + 32'd1;
        if (!pb_prog) begin
          if (pb_izq || pb_der) begin
            // Simultaneous left and right cancel; up/down is ignored this cycle.
            if (pb_izq && !pb_der)
              campo_d = (campo_q == 2'd2) ? 2'd0 : campo_q + 2'd1;
            else if (pb_der && !pb_izq)
              campo_d = (campo_q == 2'd0) ? 2'd2 : campo_q - 2'd1;
          end else if (pb_arriba ^ pb_abajo) begin
            case (campo_q)
              2'd0:    hora_d[7:0]   = bcd_paso(hora_q[7:0],   pb_arriba, MS_MIN, MS_MAX);
              2'd1:    hora_d[15:8]  = bcd_paso(hora_q[15:8],  pb_arriba, MS_MIN, MS_MAX);
              2'd2:    hora_d[23:16] = bcd_paso(hora_q[23:16], pb_arriba, HH_MIN, HH_MAX);
              default: hora_d = hora_q;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and registered data.
  always_comb begin
    hora_out  = hora_q;
    campo_sel = campo_q;
    editando  = (estado_q == EDITAR);
    wr_req    = (estado_q == ESCRIBIR);
  end

endmodule

// File: tb/tb_editor_hora_bcd.sv
// Directed bench for editor_hora_bcd: one 24h instance with a short idle
// timeout and one 12h instance without timeout, driven from vector tables.
module tb_editor_hora_bcd;

  localparam logic [5:0] BP = 6'b100000;  // pb_prog
  localparam logic [5:0] BI = 6'b010000;  // pb_izq
  localparam logic [5:0] BD = 6'b001000;  // pb_der
  localparam logic [5:0] BU = 6'b000100;  // pb_arriba
  localparam logic [5:0] BN = 6'b000010;  // pb_abajo
  localparam logic [5:0] BC = 6'b000001;  // carga
  localparam logic [5:0] B0 = 6'b000000;

  typedef struct packed {
    logic [5:0]  btn;
    logic [23:0] hin;
    logic        ack;
    logic [23:0] eh;
    logic [1:0]  ec;
    logic        ee;
    logic        ew;
  } vec_t;

  logic reloj = 1'b0;
  logic resetM = 1'b0;

  logic [5:0]  btnA = '0, btnB = '0;
  logic [23:0] hinA = '0, hinB = '0;
  logic        ackA = 1'b0, ackB = 1'b0;
  logic [23:0] horaA, horaB;
  logic [1:0]  campoA, campoB;
  logic        edA, edB, wrA, wrB;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 reloj = ~reloj;

  editor_hora_bcd #(.FORMATO_24(1'b1), .TIMEOUT_CIC(32'd10)) dut_a (
    .reloj(reloj), .resetM(resetM),
    .pb_prog(btnA[5]), .pb_izq(btnA[4]), .pb_der(btnA[3]),
    .pb_arriba(btnA[2]), .pb_abajo(btnA[1]), .carga(btnA[0]),
    .hora_in(hinA), .wr_ack(ackA),
    .hora_out(horaA), .campo_sel(campoA), .editando(edA), .wr_req(wrA)
  );

  editor_hora_bcd #(.FORMATO_24(1'b0), .TIMEOUT_CIC(32'd0)) dut_b (
    .reloj(reloj), .resetM(resetM),
    .pb_prog(btnB[5]), .pb_izq(btnB[4]), .pb_der(btnB[3]),
    .pb_arriba(btnB[2]), .pb_abajo(btnB[1]), .carga(btnB[0]),
    .hora_in(hinB), .wr_ack(ackB),
    .hora_out(horaB), .campo_sel(campoB), .editando(edB), .wr_req(wrB)
  );

  function automatic vec_t mk(input logic [5:0] b, input logic [23:0] h, input logic a,
                              input logic [23:0] eh, input logic [1:0] ec,
                              input logic ee, input logic ew);
    vec_t r;
    r.btn = b; r.hin = h; r.ack = a; r.eh = eh; r.ec = ec; r.ee = ee; r.ew = ew;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [23:0] eh, input logic [1:0] ec,
                         input logic ee, input logic ew);
    chk({tag, ".hora_out"},  horaA, eh);
    chk({tag, ".campo_sel"}, 24'(campoA), 24'(ec));
    chk({tag, ".editando"},  24'(edA), 24'(ee));
    chk({tag, ".wr_req"},    24'(wrA), 24'(ew));
  endtask

  task automatic check_b(input string tag, input logic [23:0] eh, input logic [1:0] ec,
                         input logic ee, input logic ew);
    chk({tag, ".hora_out"},  horaB, eh);
    chk({tag, ".campo_sel"}, 24'(campoB), 24'(ec));
    chk({tag, ".editando"},  24'(edB), 24'(ee));
    chk({tag, ".wr_req"},    24'(wrB), 24'(ew));
  endtask

  // Apply one vector for one clock cycle, then compare just after the edge.
  task automatic apply(input bit sel_b, input vec_t x, input int idx);
    if (!sel_b) begin btnA = x.btn; hinA = x.hin; ackA = x.ack; end
    else        begin btnB = x.btn; hinB = x.hin; ackB = x.ack; end
    @(posedge reloj); #1;
    btnA = '0; ackA = 1'b0; btnB = '0; ackB = 1'b0;
    if (!sel_b) check_a($sformatf("A[%0d]", idx), x.eh, x.ec, x.ee, x.ew);
    else        check_b($sformatf("B[%0d]", idx), x.eh, x.ec, x.ee, x.ew);
  endtask

  // Idle in EDITAR on dut_a: editing must last exactly 10 cycles, never requesting a write.
  task automatic idle_timeout(input string tag, input logic [23:0] eh, input logic [1:0] ec);
    for (int k = 1; k <= 10; k++) begin
      @(posedge reloj); #1;
      check_a($sformatf("%s[%0d]", tag, k), eh, ec, (k < 10), 1'b0);
    end
  endtask

  vec_t va[$];
  vec_t vb[$];

  initial begin
    // 24h table
    va.push_back(mk(BC,      24'h235958, 0, 24'h235958, 2'd0, 0, 0));
    va.push_back(mk(B0,      24'h000000, 0, 24'h235958, 2'd0, 0, 0));
    va.push_back(mk(BP,      24'h000000, 0, 24'h235958, 2'd0, 1, 0));
    va.push_back(mk(BI,      24'h000000, 0, 24'h235958, 2'd1, 1, 0));
    va.push_back(mk(BI,      24'h000000, 0, 24'h235958, 2'd2, 1, 0));
    va.push_back(mk(BU,      24'h000000, 0, 24'h005958, 2'd2, 1, 0));
    va.push_back(mk(BN,      24'h000000, 0, 24'h235958, 2'd2, 1, 0));
    va.push_back(mk(BU|BN,   24'h000000, 0, 24'h235958, 2'd2, 1, 0));
    va.push_back(mk(BI|BD,   24'h000000, 0, 24'h235958, 2'd2, 1, 0));
    va.push_back(mk(BD,      24'h000000, 0, 24'h235958, 2'd1, 1, 0));
    va.push_back(mk(BU,      24'h000000, 0, 24'h230058, 2'd1, 1, 0));
    va.push_back(mk(BN,      24'h000000, 0, 24'h235958, 2'd1, 1, 0));
    va.push_back(mk(BC,      24'h111111, 0, 24'h235958, 2'd1, 1, 0));
    va.push_back(mk(BD,      24'h000000, 0, 24'h235958, 2'd0, 1, 0));
    va.push_back(mk(BU,      24'h000000, 0, 24'h235959, 2'd0, 1, 0));
    va.push_back(mk(BU,      24'h000000, 0, 24'h235900, 2'd0, 1, 0));
    va.push_back(mk(BN,      24'h000000, 0, 24'h235959, 2'd0, 1, 0));
    va.push_back(mk(BD,      24'h000000, 0, 24'h235959, 2'd2, 1, 0));
    va.push_back(mk(BI,      24'h000000, 0, 24'h235959, 2'd0, 1, 0));
    va.push_back(mk(BP,      24'h000000, 0, 24'h235959, 2'd0, 0, 1));
    va.push_back(mk(BU|BI|BC,24'h010101, 0, 24'h235959, 2'd0, 0, 1));
    va.push_back(mk(BP,      24'h000000, 0, 24'h235959, 2'd0, 0, 1));
    va.push_back(mk(B0,      24'h000000, 0, 24'h235959, 2'd0, 0, 1));
    va.push_back(mk(B0,      24'h000000, 1, 24'h235959, 2'd0, 0, 0));
    va.push_back(mk(B0,      24'h000000, 1, 24'h235959, 2'd0, 0, 0));
    va.push_back(mk(BC,      24'h120009, 0, 24'h120009, 2'd0, 0, 0));
    va.push_back(mk(BP,      24'h000000, 0, 24'h120009, 2'd0, 1, 0));
    va.push_back(mk(BU,      24'h000000, 0, 24'h120010, 2'd0, 1, 0));
    va.push_back(mk(BN,      24'h000000, 0, 24'h120009, 2'd0, 1, 0));
    va.push_back(mk(BI,      24'h000000, 0, 24'h120009, 2'd1, 1, 0));
    va.push_back(mk(BI,      24'h000000, 0, 24'h120009, 2'd2, 1, 0));
    va.push_back(mk(BI,      24'h000000, 0, 24'h120009, 2'd0, 1, 0));
    va.push_back(mk(BU|BN,   24'h000000, 0, 24'h120009, 2'd0, 1, 0));
    va.push_back(mk(BI|BU,   24'h000000, 0, 24'h120009, 2'd1, 1, 0));
    va.push_back(mk(BP|BU,   24'h000000, 0, 24'h120009, 2'd1, 0, 1));
    va.push_back(mk(B0,      24'h000000, 1, 24'h120009, 2'd1, 0, 0));
    va.push_back(mk(BP|BC,   24'h075900, 0, 24'h075900, 2'd0, 1, 0));
    va.push_back(mk(BP,      24'h000000, 0, 24'h075900, 2'd0, 0, 1));
    va.push_back(mk(B0,      24'h000000, 1, 24'h075900, 2'd0, 0, 0));
    va.push_back(mk(BC,      24'h256A99, 0, 24'h256A99, 2'd0, 0, 0));
    va.push_back(mk(BP,      24'h000000, 0, 24'h256A99, 2'd0, 1, 0));
    va.push_back(mk(BU,      24'h000000, 0, 24'h256A00, 2'd0, 1, 0));
    va.push_back(mk(BU,      24'h000000, 0, 24'h256A01, 2'd0, 1, 0));
    va.push_back(mk(BI,      24'h000000, 0, 24'h256A01, 2'd1, 1, 0));
    va.push_back(mk(BN,      24'h000000, 0, 24'h250001, 2'd1, 1, 0));
    va.push_back(mk(BI,      24'h000000, 0, 24'h250001, 2'd2, 1, 0));
    va.push_back(mk(BN,      24'h000000, 0, 24'h000001, 2'd2, 1, 0));
    // 12h table
    vb.push_back(mk(BP,      24'h000000, 0, 24'h120000, 2'd0, 1, 0));
    vb.push_back(mk(BI,      24'h000000, 0, 24'h120000, 2'd1, 1, 0));
    vb.push_back(mk(BI,      24'h000000, 0, 24'h120000, 2'd2, 1, 0));
    vb.push_back(mk(BU,      24'h000000, 0, 24'h010000, 2'd2, 1, 0));
    vb.push_back(mk(BN,      24'h000000, 0, 24'h120000, 2'd2, 1, 0));
    vb.push_back(mk(BN,      24'h000000, 0, 24'h110000, 2'd2, 1, 0));
    vb.push_back(mk(BU,      24'h000000, 0, 24'h120000, 2'd2, 1, 0));
    vb.push_back(mk(BP,      24'h000000, 0, 24'h120000, 2'd2, 0, 1));
    vb.push_back(mk(B0,      24'h000000, 1, 24'h120000, 2'd2, 0, 0));
    vb.push_back(mk(BC,      24'h000000, 0, 24'h000000, 2'd2, 0, 0));
    vb.push_back(mk(BP,      24'h000000, 0, 24'h000000, 2'd0, 1, 0));
    vb.push_back(mk(BI,      24'h000000, 0, 24'h000000, 2'd1, 1, 0));
    vb.push_back(mk(BI,      24'h000000, 0, 24'h000000, 2'd2, 1, 0));
    vb.push_back(mk(BN,      24'h000000, 0, 24'h010000, 2'd2, 1, 0));
    vb.push_back(mk(BU,      24'h000000, 0, 24'h020000, 2'd2, 1, 0));

    // Reset values while reset is asserted.
    #13;
    check_a("rstA", 24'h000000, 2'd0, 1'b0, 1'b0);
    check_b("rstB", 24'h120000, 2'd0, 1'b0, 1'b0);
    #9 resetM = 1'b1;

    foreach (va[i]) apply(1'b0, va[i], i);

    // Idle timeout from the last edit, then again from a fresh entry.
    idle_timeout("tmo1", 24'h000001, 2'd2);
    apply(1'b0, mk(BP, 24'h000000, 0, 24'h000001, 2'd0, 1, 0), 100);
    idle_timeout("tmo2", 24'h000001, 2'd0);

    // Asynchronous reset in the middle of a write request.
    apply(1'b0, mk(BP, 24'h000000, 0, 24'h000001, 2'd0, 1, 0), 101);
    apply(1'b0, mk(BP, 24'h000000, 0, 24'h000001, 2'd0, 0, 1), 102);
    @(negedge reloj);
    #2 resetM = 1'b0;
    #1;
    check_a("arstA", 24'h000000, 2'd0, 1'b0, 1'b0);
    check_b("arstB", 24'h120000, 2'd0, 1'b0, 1'b0);
    @(negedge reloj);
    resetM = 1'b1;
    @(posedge reloj); #1;
    check_a("postrstA", 24'h000000, 2'd0, 1'b0, 1'b0);

    foreach (vb[i]) apply(1'b1, vb[i], i);

    // No timeout configured: editing persists while idle.
    for (int k = 1; k <= 20; k++) begin
      @(posedge reloj); #1;
      check_b($sformatf("notmo[%0d]", k), 24'h020000, 2'd2, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
